// File: rtl/utf8_pkg.sv
`default_nettype none
// ============================================================================
// Package     : utf8_pkg
// Description : Shared definitions for the UTF-8 echo queue: transmit FSM
//               state encoding, byte-count constants, queue entry width and
//               the entry packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package utf8_pkg;

  // Transmit FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_REQ  = 2'd2,
    ST_WAIT = 2'd3
  } tx_state_t;

  // Byte counts presented to the transmitter
  localparam logic [2:0] BYTES_ASCII = 3'd1;
  localparam logic [2:0] BYTES_UTF8  = 3'd3;

  // Queue entry: {is_utf8, 24-bit character}
  localparam int ENTRY_W = 25;

  // ASCII characters are zero-extended into the low byte so the transmitter
  // always sees the character right-aligned for a 1-byte send.
  function automatic logic [ENTRY_W-1:0] make_entry(input logic        is_utf8,
                                                     input logic [7:0]  ascii_in,
                                                     input logic [23:0] utf8_in);
    make_entry = is_utf8 ? {1'b1, utf8_in} : {1'b0, 16'h0000, ascii_in};
  endfunction

endpackage
`default_nettype wire

// File: rtl/utf8_echo_queue_char_fifo.sv
`default_nettype none
// ============================================================================
// Module      : char_fifo
// Description : Circular character FIFO. A push is accepted when not full, or
//               when a pop happens in the same cycle (both then take effect
//               and the count is unchanged). Storage is not reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wdata this cycle
//   pop        : advance the read pointer this cycle (rdata is the head)
//   wdata      : entry to write
//   rdata      : current head entry (combinational)
//   count      : occupancy 0..DEPTH
//   full/empty : status flags
// DEPTH must be a power of two in 2..256.
// ============================================================================
module char_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wr_ptr points at; the head is read before the write lands.
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/utf8_echo_queue.sv
`default_nettype none
// ============================================================================
// Module      : utf8_echo_queue
// Description : Queues characters from a UART receive front end (ASCII or
//               3-byte UTF-8) and hands them one at a time to a transmitter
//               using an en / sending / sent handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   received       : character-ready level; one push per rising edge
//   is_utf8        : 1 = utf8_in is valid, 0 = ascii_in is valid
//   ascii_in       : ASCII character
//   utf8_in        : UTF-8 character, lead byte in [23:16]
//   sending        : transmitter busy level
//   sent           : transmitter completion pulse
//   data_to_send   : character presented to the transmitter
//   bytes_to_send  : 1 (ASCII) or 3 (UTF-8)
//   en             : transmit request, high only in REQ
//   count          : FIFO occupancy
//   full, empty    : FIFO status
//   overflow       : sticky, a character was dropped (cleared by reset only)
// ============================================================================
module utf8_echo_queue
  import utf8_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             received,
  input  logic             is_utf8,
  input  logic [7:0]       ascii_in,
  input  logic [23:0]      utf8_in,
  input  logic             sending,
  input  logic             sent,
  output logic [23:0]      data_to_send,
  output logic [2:0]       bytes_to_send,
  output logic             en,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  tx_state_t          state_q;
  tx_state_t          state_d;
  logic               received_q;
  logic               push_edge;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  assign push_edge = received && !received_q;

  char_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_edge),
    .pop   (pop),
    .wdata (make_entry(is_utf8, ascii_in, utf8_in)),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      received_q <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      received_q <= received;
      // Same drop rule the FIFO applies: full and not popping this cycle.
      if (push_edge && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    en      = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) state_d = ST_LOAD;
      ST_LOAD: begin
        pop     = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        en = 1'b1;
        if (sending) state_d = ST_WAIT;
      end
      ST_WAIT: if (sent || !sending) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output character is only written in LOAD, so it holds through REQ/WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_to_send  <= 24'h000000;
      bytes_to_send <= 3'd0;
    end else if (pop) begin
      data_to_send  <= head[23:0];
      bytes_to_send <= head[ENTRY_W-1] ? BYTES_UTF8 : BYTES_ASCII;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_utf8_echo_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_utf8_echo_queue
// Description : Self-checking bench for utf8_echo_queue. Stimulus pushes the
//               expected characters into a scoreboard queue; a monitor pops
//               and compares each time a new transmit request appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_utf8_echo_queue;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             received = 1'b0;
  logic             is_utf8 = 1'b0;
  logic [7:0]       ascii_in = 8'h00;
  logic [23:0]      utf8_in = 24'h000000;
  logic             sending;
  logic             sent;
  logic [23:0]      data_to_send;
  logic [2:0]       bytes_to_send;
  logic             en;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;

  // Transmitter: automatic model when tx_on, otherwise driven by hand.
  logic tx_on = 1'b0;
  logic tx_sending = 1'b0;
  logic tx_sent = 1'b0;
  logic man_sending = 1'b0;
  logic man_sent = 1'b0;
  assign sending = tx_on ? tx_sending : man_sending;
  assign sent    = tx_on ? tx_sent    : man_sent;

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q[$];

  utf8_echo_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .received      (received),
    .is_utf8       (is_utf8),
    .ascii_in      (ascii_in),
    .utf8_in       (utf8_in),
    .sending       (sending),
    .sent          (sent),
    .data_to_send  (data_to_send),
    .bytes_to_send (bytes_to_send),
    .en            (en),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Push one character; acc says whether the reference expects it accepted.
  task automatic push_val(input logic u, input logic [7:0] a, input logic [23:0] w,
                          input logic acc);
    @(negedge clk);
    is_utf8  = u;
    ascii_in = a;
    utf8_in  = w;
    received = 1'b1;
    if (acc) exp_q.push_back(u ? {1'b1, w} : {1'b0, 16'h0000, a});
    @(negedge clk);
    received = 1'b0;
  endtask

  task automatic push_rand(input logic acc);
    logic        u;
    logic [7:0]  a;
    logic [23:0] w;
    u = 1'($urandom_range(0, 1));
    a = 8'($urandom);
    w = 24'($urandom);
    push_val(u, a, w, acc);
  endtask

  task automatic wait_en();
    for (int i = 0; i < 100 && !en; i++) @(negedge clk);
    check("wait_en", {31'd0, en}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_left", exp_q.size(), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  // Monitor: compare each new transfer against the scoreboard head and
  // require the presented character to hold while en stays high.
  initial begin : monitor
    logic        seen;
    logic [24:0] e;
    seen = 1'b0;
    e    = '0;
    forever begin
      @(negedge clk);
      if (!en) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got data %h, required no transfer", data_to_send);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", {8'd0, data_to_send}, {8'd0, e[23:0]});
          check("tx_bytes", {29'd0, bytes_to_send}, e[24] ? 32'd3 : 32'd1);
        end
      end else begin
        check("tx_stable", {5'd0, bytes_to_send, data_to_send},
              {5'd0, e[24] ? 3'd3 : 3'd1, e[23:0]});
      end
    end
  end

  // Transmitter model with random response and busy times.
  initial begin : tx_model
    forever begin
      @(negedge clk);
      if (tx_on && en) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        tx_sending = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        tx_sending = 1'b0;
        tx_sent    = 1'b1;
        @(negedge clk);
        tx_sent = 1'b0;
      end
    end
  end

  initial begin : stim
    logic saw_en;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_en", {31'd0, en}, 32'd0);
    check("rst_count", {{(32-CNT_W){1'b0}}, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_data", {8'd0, data_to_send}, 32'd0);
    check("rst_bytes", {29'd0, bytes_to_send}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ASCII 'A' with received held for 5 cycles: one push, en 3 cycles later
    @(negedge clk);
    is_utf8  = 1'b0;
    ascii_in = 8'h41;
    utf8_in  = 24'h123456;
    received = 1'b1;
    exp_q.push_back({1'b0, 24'h000041});
    @(negedge clk); check("lat_c1", {31'd0, en}, 32'd0);
    @(negedge clk); check("lat_c2", {31'd0, en}, 32'd0);
    @(negedge clk); check("lat_c3", {31'd0, en}, 32'd1);
    repeat (2) @(negedge clk);
    received = 1'b0;
    check("en_held", {31'd0, en}, 32'd1);
    man_sending = 1'b1;
    @(negedge clk);
    check("en_drop_ascii", {31'd0, en}, 32'd0);
    check("single_push", {{(32-CNT_W){1'b0}}, count}, 32'd0);
    man_sending = 1'b0;
    repeat (6) @(negedge clk);

    // UTF-8 character
    push_val(1'b1, 8'h5A, 24'hE0B881, 1'b1);
    wait_en();
    man_sending = 1'b1;
    @(negedge clk);
    check("en_drop_utf8", {31'd0, en}, 32'd0);
    man_sending = 1'b0;
    repeat (4) @(negedge clk);

    // Long random stream through the live transmitter; never overfill
    tx_on = 1'b1;
    for (int n = 0; n < 3 * DEPTH; n++) begin
      for (int i = 0; i < 500 && exp_q.size() >= DEPTH; i++) @(negedge clk);
      push_rand(1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check("wrap_count", {{(32-CNT_W){1'b0}}, count}, 32'd0);
    check("wrap_empty", {31'd0, empty}, 32'd1);
    check("wrap_overflow", {31'd0, overflow}, 32'd0);
    tx_on = 1'b0;

    // Full FIFO: the LOAD pop coincides with a new push
    push_rand(1'b1);
    wait_en();
    for (int n = 0; n < DEPTH; n++) push_rand(1'b1);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_count", {{(32-CNT_W){1'b0}}, count}, DEPTH);
    man_sending = 1'b1;          // REQ -> WAIT
    @(negedge clk);
    man_sending = 1'b0;          // WAIT -> IDLE
    man_sent    = 1'b1;
    @(negedge clk);
    man_sent = 1'b0;             // IDLE -> LOAD at the next edge
    push_rand(1'b1);             // push lands on the LOAD edge
    check("pp_count", {{(32-CNT_W){1'b0}}, count}, DEPTH);
    check("pp_full", {31'd0, full}, 32'd1);
    check("pp_overflow", {31'd0, overflow}, 32'd0);
    tx_on = 1'b1;
    drain();
    tx_on = 1'b0;

    // Stalled transmitter: DEPTH+2 pushes, last one dropped
    push_rand(1'b1);
    wait_en();
    for (int n = 0; n < DEPTH + 1; n++) push_rand(n < DEPTH);
    check("ovf_count", {{(32-CNT_W){1'b0}}, count}, DEPTH);
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    tx_on = 1'b1;
    drain();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_drained", {31'd0, empty}, 32'd1);
    tx_on = 1'b0;

    // Reset during WAIT with 4 entries queued
    push_rand(1'b1);
    wait_en();
    for (int n = 0; n < 4; n++) push_rand(1'b1);
    check("pre_rst_count", {{(32-CNT_W){1'b0}}, count}, 32'd4);
    man_sending = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", {31'd0, en}, 32'd0);
    check("mid_rst_count", {{(32-CNT_W){1'b0}}, count}, 32'd0);
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    check("mid_rst_bytes", {29'd0, bytes_to_send}, 32'd0);
    exp_q.delete();
    man_sending = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    saw_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (en) saw_en = 1'b1;
    end
    check("no_en_after_rst", {31'd0, saw_en}, 32'd0);
    tx_on = 1'b1;
    push_rand(1'b1);
    drain();
    check("post_rst_count", {{(32-CNT_W){1'b0}}, count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/utf8_echo_queue.md
UTF8_ECHO_QUEUE -- requirements
Module: utf8_echo_queue

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the character FIFO depth in entries and SHALL be a power of two, 2..256.
REQ-002 Parameter CNT_W, default $clog2(DEPTH)+1, SHALL set the width of count.
REQ-003 clk  input  1  single clock for the block.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 received  input  1  character-ready level from the UART receive front end.
REQ-006 is_utf8  input  1  1 means the current character is 3-byte UTF-8; 0 means ASCII.
REQ-007 ascii_in  input  8  ASCII character, valid when is_utf8=0.
REQ-008 utf8_in  input  24  UTF-8 character with lead byte in [23:16], valid when is_utf8=1.
REQ-009 sending  input  1  transmitter busy level.
REQ-010 sent  input  1  transmitter completion pulse.
REQ-011 data_to_send  output  24  character presented to the transmitter.
REQ-012 bytes_to_send  output  3  byte count presented to the transmitter (1 or 3).
REQ-013 en  output  1  transmit request.
REQ-014 count  output  CNT_W  current FIFO occupancy.
REQ-015 full / empty  output  1 each  FIFO status flags.
REQ-016 overflow  output  1  sticky flag: a character was dropped.

Function
REQ-017 Push SHALL occur only on the rising edge of received (registered previous value, 0->1), never repeatedly while received stays high.
REQ-018 A pushed entry SHALL be {is_utf8, is_utf8 ? utf8_in : {16'h0000, ascii_in}}, 25 bits, captured in the push cycle.
REQ-019 The FIFO SHALL be circular with read/write pointers that wrap modulo DEPTH; count SHALL be in 0..DEPTH; full=(count==DEPTH); empty=(count==0).
REQ-020 A push while full with no pop in the same cycle SHALL be dropped, SHALL set overflow, and SHALL leave the FIFO unchanged.
REQ-021 A push and a pop in the same cycle SHALL both take effect and leave count unchanged, including when the FIFO is full.
REQ-022 The transmit FSM SHALL have states IDLE, LOAD, REQ, WAIT.
REQ-023 IDLE->LOAD SHALL occur when the FIFO is not empty; LOAD SHALL pop the head entry into the data_to_send / bytes_to_send registers (3 if the entry flag is 1, else 1) and go to REQ.
REQ-024 In REQ, en SHALL be 1 and SHALL stay 1 until sending=1 is sampled; then the FSM SHALL go to WAIT with en=0.
REQ-025 WAIT->IDLE SHALL occur when sent=1 or sending=0 is sampled.
REQ-026 Minimum latency from the push edge to en=1 SHALL be 3 clk cycles when the FIFO is empty and the FSM is IDLE.
REQ-027 data_to_send and bytes_to_send SHALL stay stable from LOAD until the FSM returns to IDLE.
REQ-028 en SHALL be 1 only in REQ.
REQ-029 overflow SHALL clear only on reset.

Reset
REQ-030 When rst_n=0, the block SHALL immediately enter: FSM=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, en=0, data_to_send=0, bytes_to_send=0, received-edge register=0.
REQ-031 FIFO storage SHALL NOT require reset.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer and discard all queued entries.
REQ-033 After reset release, the first push SHALL still require a 0->1 edge on received.

Structure
REQ-034 A shared package utf8_pkg SHALL hold the FSM state encoding, the BYTES_ASCII=1 and BYTES_UTF8=3 constants, and the 25-bit entry width.
REQ-035 The storage SHALL be a sub-module char_fifo (parameterised DEPTH/width, push, pop, count, full, empty).
REQ-036 The FSM and edge detection SHALL live in utf8_echo_queue.

Verification
REQ-037 ASCII 8'h41 with received held high for 5 cycles -> exactly one push; en=1 three cycles after the edge; data_to_send=24'h000041; bytes_to_send=1.
REQ-038 UTF-8 24'hE0B881 with is_utf8=1 -> data_to_send=24'hE0B881, bytes_to_send=3; en drops the cycle after sending=1.
REQ-039 With sending held 0 (transmitter stalled), push DEPTH+2 characters -> count=DEPTH, full=1, overflow=1, and the first DEPTH characters are later sent in order.
REQ-040 FIFO full while a LOAD pop coincides with a new push -> count stays DEPTH, overflow stays 0, and the new character is sent last.
REQ-041 rst_n pulsed low during WAIT with 4 entries queued -> en=0, count=0, empty=1 immediately; no further en until a new push.
REQ-042 Push 3*DEPTH characters with the transmitter modelled -> pointers wrap, output order matches input order, and count returns to 0.
